// File: rtl/expand_a_scheduler.sv
// Walks ExpandA entries (i,j) row-major: launch SHAKE128 core, forward each rate block, squeeze on demand.
// Latency: g_start one cycle after accepted start; blk_valid one cycle after g_done. Backpressure: PRESENT holds until blk_ready.
// Optional EXPANDA_SQZ_LIMIT_EN adds MAX_SQZ: exceeding it raises sticky err and ends the run early.
module expand_a_scheduler #(
    parameter int K    = 6,
    parameter int L    = 5,
    parameter int RATE = 1344
`ifdef EXPANDA_SQZ_LIMIT_EN
    ,
    parameter int MAX_SQZ = 8
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [255:0]    rho,
    output logic            busy,
    output logic            done,
    output logic            g_start,
    output logic            g_squeeze,
    output logic [255:0]    g_rho,
    output logic [7:0]      g_i,
    output logic [7:0]      g_j,
    input  logic            g_done,
    input  logic [1599:0]   g_keccak_output,
    output logic            blk_valid,
    input  logic            blk_ready,
    output logic [RATE-1:0] blk_data,
    output logic [7:0]      blk_i,
    output logic [7:0]      blk_j,
    input  logic            samp_more,
    input  logic            samp_done,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_G, S_PRESENT, S_WAIT_SAMP, S_SQUEEZE, S_FINISH
    } state_t;

    localparam logic [7:0] LAST_I = 8'(K - 1);
    localparam logic [7:0] LAST_J = 8'(L - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [255:0]    r_rho;
    logic [7:0]      r_i;
    logic [7:0]      r_j;
    logic [RATE-1:0] r_blk_data;
    logic [7:0]      r_blk_i;
    logic [7:0]      r_blk_j;
    logic [7:0]      r_sqz_cnt;

    logic w_accept_start;
    logic w_load_blk;
    logic w_next_entry;
    logic w_sqz_inc;
    logic w_sqz_clr;
    logic w_set_err;
    logic w_last_entry;
    logic w_sqz_limit;
    logic w_unused_state;

    assign w_last_entry   = (r_i == LAST_I) && (r_j == LAST_J);
    assign w_unused_state = ^g_keccak_output[1599:RATE];

`ifdef EXPANDA_SQZ_LIMIT_EN
    assign w_sqz_limit = (r_sqz_cnt == 8'(MAX_SQZ));
`else
    assign w_sqz_limit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_accept_start = 1'b0;
        w_load_blk     = 1'b0;
        w_next_entry   = 1'b0;
        w_sqz_inc      = 1'b0;
        w_sqz_clr      = 1'b0;
        w_set_err      = 1'b0;
        busy           = (r_state != S_IDLE) && (r_state != S_FINISH);
        done           = (r_state == S_FINISH);
        g_start        = (r_state == S_LAUNCH);
        g_squeeze      = (r_state == S_SQUEEZE);
        blk_valid      = (r_state == S_PRESENT);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept_start = 1'b1;
                    w_state_nxt    = S_LAUNCH;
                end
            end
            S_LAUNCH:  w_state_nxt = S_WAIT_G;
            S_WAIT_G: begin
                if (g_done) begin
                    w_load_blk  = 1'b1;
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (blk_ready) w_state_nxt = S_WAIT_SAMP;
            end
            S_WAIT_SAMP: begin
                // samp_done has priority over a coincident samp_more
                if (samp_done) begin
                    w_sqz_clr = 1'b1;
                    if (w_last_entry) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_next_entry = 1'b1;
                        w_state_nxt  = S_LAUNCH;
                    end
                end else if (samp_more) begin
                    if (w_sqz_limit) begin
                        w_set_err   = 1'b1;
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = S_SQUEEZE;
                    end
                end
            end
            S_SQUEEZE: begin
                w_sqz_inc   = 1'b1;
                w_state_nxt = S_WAIT_G;
            end
            S_FINISH:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rho      <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_blk_data <= '0;
            r_blk_i    <= '0;
            r_blk_j    <= '0;
            r_sqz_cnt  <= '0;
        end else begin
            if (w_accept_start) begin
                r_rho <= rho;
                r_i   <= '0;
                r_j   <= '0;
            end
            if (w_next_entry) begin
                if (r_j == LAST_J) begin
                    r_j <= '0;
                    r_i <= r_i + 8'd1;
                end else begin
                    r_j <= r_j + 8'd1;
                end
            end
            if (w_load_blk) begin
                r_blk_data <= g_keccak_output[RATE-1:0];
                r_blk_i    <= r_i;
                r_blk_j    <= r_j;
            end
            if (w_accept_start || w_sqz_clr) r_sqz_cnt <= '0;
            else if (w_sqz_inc)              r_sqz_cnt <= r_sqz_cnt + 8'd1;
        end
    end

`ifdef EXPANDA_SQZ_LIMIT_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_err <= 1'b0;
        else if (w_accept_start) r_err <= 1'b0;
        else if (w_set_err)      r_err <= 1'b1;
    end

    assign err = r_err;
`else
    logic w_unused_err;
    assign w_unused_err = w_set_err;
    assign err          = 1'b0;
`endif

    assign g_rho    = r_rho;
    assign g_i      = r_i;
    assign g_j      = r_j;
    assign blk_data = r_blk_data;
    assign blk_i    = r_blk_i;
    assign blk_j    = r_blk_j;

endmodule

// File: doc/expand_a_scheduler.md
Name: expand_a_scheduler

Overview:
Sequences the G_function_top SHAKE128 core across every (i,j) entry of the Dilithium ExpandA matrix A (K rows x L columns). For each entry it latches the seed, launches the core and hands each 1344-bit rate block to the downstream rejection sampler through a valid/ready handshake. When the sampler asks for more bytes it requests additional squeezes, then moves to the next entry. It sits between the key-gen/sign top-level FSM and the G_function_top/sampler pair.

Parameters:
K, 6, number of matrix rows (i range 0..K-1)
L, 5, number of matrix columns (j range 0..L-1)
RATE, 1344, SHAKE128 rate in bits forwarded per block

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begin expansion of the full matrix
rho  input  256  seed; sampled only on the accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after the last entry completes
g_start  output  1  one-cycle pulse; core absorbs rho||j||i and permutes
g_squeeze  output  1  one-cycle pulse; core permutes again (next rate block)
g_rho  output  256  latched seed to core
g_i  output  8  current row index
g_j  output  8  current column index
g_done  input  1  one-cycle pulse; core permutation finished
g_keccak_output  input  1600  core state
blk_valid  output  1  rate block available to sampler
blk_ready  input  1  sampler accepts block
blk_data  output  RATE  g_keccak_output[RATE-1:0], registered on g_done
blk_i  output  8  row of blk_data
blk_j  output  8  column of blk_data
samp_more  input  1  pulse; sampler exhausted block, needs another
samp_done  input  1  pulse; current polynomial complete
err  output  1  sticky squeeze-limit error (see Optional Feature)

Behaviour:
- Reset (async, any state): state IDLE; busy, done, g_start, g_squeeze, blk_valid, err = 0; g_rho, g_i, g_j, blk_data, blk_i, blk_j = 0; squeeze counter = 0.
- States: IDLE, LAUNCH, WAIT_G, PRESENT, WAIT_SAMP, SQUEEZE, FINISH.
- IDLE: start=1 -> latch rho into g_rho, g_i=g_j=0, busy=1, go LAUNCH. start while busy is ignored.
- LAUNCH: assert g_start for exactly one cycle (cycle after accepted start), go WAIT_G.
- SQUEEZE: assert g_squeeze for exactly one cycle, increment squeeze counter, go WAIT_G.
- WAIT_G: on g_done register blk_data, blk_i=g_i, blk_j=g_j; next cycle blk_valid=1, go PRESENT. g_done in any other state is ignored.
- PRESENT: blk_valid held, blk_data stable until blk_valid&&blk_ready; then blk_valid=0, go WAIT_SAMP.
- WAIT_SAMP: samp_done -> reset squeeze counter; if g_j==L-1 and g_i==K-1 go FINISH; else advance j (wrap to 0, i+1 when j==L-1), go LAUNCH. samp_more -> go SQUEEZE. Both in same cycle: samp_done wins. Samp pulses outside WAIT_SAMP are ignored.
- Order is row-major: (0,0),(0,1)..(0,L-1),(1,0)..(K-1,L-1); exactly K*L g_start pulses per run.
- FINISH: done=1 for one cycle, busy=0, go IDLE. New start accepted the cycle after done.
- g_rho/g_i/g_j stable from LAUNCH through the matching g_done.
- Reset mid-run aborts silently; no done pulse; core outputs ignored until next start.

Optional Feature:
EXPANDA_SQZ_LIMIT_EN: adds parameter MAX_SQZ (default 8). If samp_more arrives in WAIT_SAMP when the squeeze counter == MAX_SQZ, set err=1 (sticky until reset or next accepted start), skip remaining entries, go FINISH (done still pulses). Without the macro, squeezes are unbounded and err is tied to 0.

Test Plan:
- Reset, start with rho=0x0f2ebf0e...deda1f1c, stub core g_done 24 cycles after each g_start, sampler ready and samp_done on every block -> 30 g_start pulses in (i,j) row-major order, one done, busy low afterwards.
- Entry (1,1): samp_more twice then samp_done -> 2 g_squeeze pulses, 3 blocks all tagged blk_i=1, blk_j=1, then g_start for (1,2).
- blk_ready held low 10 cycles -> blk_valid stays high, blk_data constant, no g_start/g_squeeze issued.
- start pulsed again during WAIT_G, and samp_done/samp_more asserted together -> second start ignored, g_rho unchanged; samp_done path taken.
- rst_n low during entry (2,3) PRESENT -> all outputs at reset values immediately; next start restarts at (0,0).
- With EXPANDA_SQZ_LIMIT_EN, MAX_SQZ=2: third samp_more on one entry -> err=1, done pulses, no further g_start; without macro same stimulus gives third g_squeeze and err=0.
